// File: rtl/text_palette_lut.sv
// Text-mode colour stage: glyph bit plus fg/bg attribute index a writable palette (CGA-16 at reset).
// Two-clock pipeline with the sideband delayed to match, and a frame-counted blink phase.
module text_palette_lut #(
    parameter int INDEX_W      = 4,
    parameter int COLOR_W      = 8,
    parameter int SB_W         = 3,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pix_valid,
    input  logic                   pix_on,
    input  logic [INDEX_W-1:0]     fg_index,
    input  logic [INDEX_W-1:0]     bg_index,
    input  logic                   blink_attr,
    input  logic                   blink_en,
    input  logic                   frame_start,
    input  logic [SB_W-1:0]        sb_in,
    input  logic                   wr_en,
    input  logic [INDEX_W-1:0]     wr_addr,
    input  logic [3*COLOR_W-1:0]   wr_data,
    output logic [3*COLOR_W-1:0]   rgb_out,
    output logic                   rgb_valid,
    output logic [SB_W-1:0]        sb_out,
    output logic                   blink_phase
);

    localparam int DEPTH = 2 ** INDEX_W;
    localparam int RGB_W = 3 * COLOR_W;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [RGB_W-1:0]   palette [DEPTH];
    logic [INDEX_W-1:0] sel;
    logic [INDEX_W-1:0] sel_r;
    logic               valid_r;
    logic [SB_W-1:0]    sb_r;
    logic [CNT_W-1:0]   frame_cnt;

    // A 2-bit level replicated across the channel gives 00/55/AA/FF at 8 bits.
    function automatic logic [COLOR_W-1:0] level(input logic [1:0] l);
        return {(COLOR_W / 2){l}};
    endfunction

    function automatic logic [RGB_W-1:0] cga_default(input int idx);
        logic [5:0] lv;
        lv = 6'b00_00_00;
        case (idx)
            1:  lv = 6'b00_00_10;
            2:  lv = 6'b00_10_00;
            3:  lv = 6'b00_10_10;
            4:  lv = 6'b10_00_00;
            5:  lv = 6'b10_00_10;
            6:  lv = 6'b10_01_00;
            7:  lv = 6'b10_10_10;
            8:  lv = 6'b01_01_01;
            9:  lv = 6'b01_01_11;
            10: lv = 6'b01_11_01;
            11: lv = 6'b01_11_11;
            12: lv = 6'b11_01_01;
            13: lv = 6'b11_01_11;
            14: lv = 6'b11_11_01;
            15: lv = 6'b11_11_11;
            default: lv = 6'b00_00_00;
        endcase
        return {level(lv[5:4]), level(lv[3:2]), level(lv[1:0])};
    endfunction

    always_comb begin
        sel = bg_index;
        if (pix_on && !(blink_en && blink_attr && blink_phase))
            sel = fg_index;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                palette[i] <= cga_default(i);
        end else if (wr_en) begin
            palette[wr_addr] <= wr_data;
        end
    end

    // Stage 2 reads before the same-edge write lands, so a colliding read sees the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r     <= '0;
            valid_r   <= 1'b0;
            sb_r      <= '0;
            rgb_out   <= '0;
            rgb_valid <= 1'b0;
            sb_out    <= '0;
        end else begin
            sel_r     <= sel;
            valid_r   <= pix_valid;
            sb_r      <= sb_in;
            rgb_out   <= palette[sel_r];
            rgb_valid <= valid_r;
            sb_out    <= sb_r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == CNT_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_text_palette_lut.sv
// Bench for text_palette_lut: directed scenarios then random traffic, checked against a
// palette/frame-count reference model; a second narrow instance covers COLOR_W=4, INDEX_W=5.
module tb_text_palette_lut;

    localparam int IW = 4;
    localparam int CW = 8;
    localparam int SW = 3;
    localparam int BF = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pix_valid, pix_on, blink_attr, blink_en, frame_start, wr_en;
    logic [IW-1:0] fg_index, bg_index, wr_addr;
    logic [SW-1:0] sb_in;
    logic [23:0]   wr_data;
    logic [23:0]   rgb_out;
    logic          rgb_valid, blink_phase;
    logic [SW-1:0] sb_out;

    logic [4:0]    s_fg;
    logic [11:0]   s_rgb;
    logic          s_valid, s_phase;
    logic [2:0]    s_sb;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    text_palette_lut #(.INDEX_W(IW), .COLOR_W(CW), .SB_W(SW), .BLINK_FRAMES(BF)) u_dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_on(pix_on),
        .fg_index(fg_index), .bg_index(bg_index), .blink_attr(blink_attr), .blink_en(blink_en),
        .frame_start(frame_start), .sb_in(sb_in), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rgb_out(rgb_out), .rgb_valid(rgb_valid), .sb_out(sb_out),
        .blink_phase(blink_phase)
    );

    text_palette_lut #(.INDEX_W(5), .COLOR_W(4), .SB_W(3), .BLINK_FRAMES(2)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .pix_valid(1'b1), .pix_on(1'b1),
        .fg_index(s_fg), .bg_index(5'd0), .blink_attr(1'b0), .blink_en(1'b0),
        .frame_start(1'b0), .sb_in(3'd0), .wr_en(1'b0), .wr_addr(5'd0),
        .wr_data(12'd0), .rgb_out(s_rgb), .rgb_valid(s_valid), .sb_out(s_sb),
        .blink_phase(s_phase)
    );

    // Reference model: palette contents, total frame pulses, and the pixel accepted last cycle.
    int            cga_tab [16] = '{'h000, 'h002, 'h020, 'h022, 'h200, 'h202, 'h210, 'h222,
                                    'h111, 'h113, 'h131, 'h133, 'h311, 'h313, 'h331, 'h333};
    logic [23:0]   mpal [16];
    int            frames;
    int            prev_idx;
    logic          prev_valid;
    logic [SW-1:0] prev_sb;

    function automatic logic [23:0] ref_default(input int i);
        int lv, full, r, g, b;
        lv   = cga_tab[i];
        full = (1 << CW) - 1;
        r = ((lv >> 8) & 15) * full / 3;
        g = ((lv >> 4) & 15) * full / 3;
        b = (lv & 15) * full / 3;
        return 24'((r << 16) | (g << 8) | b);
    endfunction

    function automatic logic model_phase();
        return 1'((frames / BF) % 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mpal[i] = ref_default(i);
        frames     = 0;
        prev_idx   = 0;
        prev_valid = 1'b0;
        prev_sb    = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs present at this edge, then compare outputs.
    task automatic step();
        logic [23:0]   exp_rgb;
        logic          exp_valid;
        logic [SW-1:0] exp_sb;
        @(posedge clk);
        exp_rgb   = mpal[prev_idx];
        exp_valid = prev_valid;
        exp_sb    = prev_sb;
        if (pix_on && !(blink_en && blink_attr && model_phase())) prev_idx = int'(fg_index);
        else prev_idx = int'(bg_index);
        prev_valid = pix_valid;
        prev_sb    = sb_in;
        if (wr_en) mpal[wr_addr] = wr_data;
        if (frame_start) frames++;
        #1;
        chk("rgb_out", 32'(rgb_out), 32'(exp_rgb));
        chk("rgb_valid", 32'(rgb_valid), 32'(exp_valid));
        chk("sb_out", 32'(sb_out), 32'(exp_sb));
        chk("blink_phase", 32'(blink_phase), 32'(model_phase()));
    endtask

    task automatic idle_inputs();
        pix_valid = 1'b0; pix_on = 1'b0; blink_attr = 1'b0; blink_en = 1'b0;
        frame_start = 1'b0; wr_en = 1'b0; fg_index = '0; bg_index = '0;
        wr_addr = '0; wr_data = '0; sb_in = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        s_fg = 5'd6;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rgb", 32'(rgb_out), 32'h0);
        chk("reset_valid", 32'(rgb_valid), 32'h0);
        chk("reset_sb", 32'(sb_out), 32'h0);
        chk("reset_phase", 32'(blink_phase), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Default palette sweep through the foreground path.
        pix_valid = 1'b1; pix_on = 1'b1;
        for (int i = 0; i < 16; i++) begin
            fg_index = IW'(i);
            step();
        end
        step();
        chk("t1_white", 32'(rgb_out), 32'hFFFFFF);
        chk("small_idx6", 32'(s_rgb), 32'hA50);
        s_fg = 5'd20;
        step(); step();
        chk("small_idx20", 32'(s_rgb), 32'h000);
        s_fg = 5'd15;

        // Palette writes, including a write colliding with a stage-2 read.
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 24'h123456; fg_index = 4'd1;
        step();
        wr_en = 1'b0;
        step();
        chk("t2_new_idx1", 32'(rgb_out), 32'h123456);
        fg_index = 4'd4;
        step();
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 24'h123456;
        step();
        chk("t2_old_idx4", 32'(rgb_out), 32'hAA0000);
        wr_en = 1'b0;
        step();
        chk("t2_new_idx4", 32'(rgb_out), 32'h123456);
        chk("small_idx15", 32'(s_rgb), 32'hFFF);

        // Background path and sideband alignment.
        pix_on = 1'b0; bg_index = 4'd14; fg_index = 4'd1;
        for (int i = 0; i < 6; i++) begin
            sb_in = (i % 2 == 0) ? 3'b101 : 3'b010;
            pix_valid = 1'(i % 3 != 2);
            step();
        end
        step();
        chk("t3_bg14", 32'(rgb_out), 32'hFFFF55);

        // Blink: two frame pulses flip the phase and the glyph falls back to bg.
        pix_valid = 1'b1; pix_on = 1'b1; fg_index = 4'd15; bg_index = 4'd0;
        blink_en = 1'b1; blink_attr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            frame_start = 1'b1; step();
            frame_start = 1'b0; step();
        end
        step(); step();
        chk("t4_blink_phase", 32'(blink_phase), 32'h1);
        chk("t4_blinked", 32'(rgb_out), 32'h000000);
        blink_en = 1'b0;
        step(); step();
        chk("t5_blink_off", 32'(rgb_out), 32'hFFFFFF);
        blink_en = 1'b1; blink_attr = 1'b0;
        step(); step();
        chk("t5_attr_off", 32'(rgb_out), 32'hFFFFFF);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            pix_valid   = 1'($urandom);
            pix_on      = 1'($urandom);
            fg_index    = IW'($urandom);
            bg_index    = IW'($urandom);
            blink_attr  = 1'($urandom);
            blink_en    = 1'($urandom);
            frame_start = ($urandom_range(0, 3) == 0);
            wr_en       = ($urandom_range(0, 7) == 0);
            wr_addr     = IW'($urandom);
            wr_data     = 24'($urandom);
            sb_in       = SW'($urandom);
            step();
        end

        // Mid-stream reset clears outputs at once and restores default colours.
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rgb", 32'(rgb_out), 32'h0);
        chk("mid_rst_valid", 32'(rgb_valid), 32'h0);
        chk("mid_rst_sb", 32'(sb_out), 32'h0);
        chk("mid_rst_phase", 32'(blink_phase), 32'h0);
        chk("mid_rst_small", 32'(s_rgb), 32'h0);
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        pix_valid = 1'b1; pix_on = 1'b1;
        for (int i = 0; i < 16; i++) begin
            fg_index = IW'(i);
            step();
        end
        step();
        chk("post_rst_white", 32'(rgb_out), 32'hFFFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
